alu_exec_unit: RTL and testbench

- Execution stage directly downstream of the ALU control decoder; consumes its 4-bit operation code plus two operands and produces result, zero and overflow flags.
- Single-cycle ops (AND, OR, ADD, SUB, SLT, NOR) complete with a one-cycle registered latency.
- A team-defined extension opcode runs a WIDTH-cycle iterative unsigned multiply.
- A start/busy/done handshake lets the datapath control stall while a multiply runs.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_exec_unit_if.sv | 32 +++
 rtl/shift_add_multiplier.sv | 75 +++++++
 rtl/alu_exec_unit.sv | 155 +++++++++++++++
 tb/tb_alu_exec_unit.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU control decoder and the execution
// unit. Holds the 4-bit operation codes produced by the decoder and the
// state encoding of the execution unit's control FSM.
package alu_pkg;

  localparam logic [3:0] OP_AND             = 4'b0000;
  localparam logic [3:0] OP_OR              = 4'b0001;
  localparam logic [3:0] OP_ADD             = 4'b0010;
  localparam logic [3:0] OP_SUB             = 4'b0110;
  localparam logic [3:0] OP_SLT             = 4'b0111;
  localparam logic [3:0] OP_NOR             = 4'b1100;
  localparam logic [3:0] OP_MUL             = 4'b1000;
  // Code the decoder emits when it does not recognise an instruction.
  localparam logic [3:0] OP_ILLEGAL_DEFAULT = 4'b1111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: request/response bundle between datapath control and the
// execution unit.
//   start/operation/a/b      : request, driven by the master (datapath control)
//   busy/done                : handshake, driven by the slave (execution unit)
//   result/hi/zero/overflow/illegal : registered response from the slave
interface alu_exec_unit_if #(
  parameter int WIDTH = 32
) ();

  logic             start;
  logic [3:0]       operation;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic             zero;
  logic             overflow;
  logic             illegal;

  modport master (
    output start, operation, a, b,
    input  busy, done, result, hi, zero, overflow, illegal
  );

  modport slave (
    input  start, operation, a, b,
    output busy, done, result, hi, zero, overflow, illegal
  );

endinterface

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: WIDTH-step unsigned shift-add multiplier.
//   clk, rstn        : clock, asynchronous active-low reset
//   load             : capture a_in (multiplicand) / b_in (multiplier), arm counter
//   step             : perform one shift-add iteration
//   a_in, b_in       : operands sampled on load
//   last             : the current step is the final one
//   next_lo, next_hi : product value that the current step produces
// The upper half of the product register starts cleared; the lower half is
// seeded with the multiplier, whose bits shift out at the bottom as product
// bits shift in at the top, so the LSB of the register is always the
// multiplier bit for the current step.
module shift_add_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             last,
  output logic [WIDTH-1:0] next_lo,
  output logic [WIDTH-1:0] next_hi
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0]      count_q, count_d;
  logic [WIDTH:0]     partial;
  logic [2*WIDTH-1:0] step_prod;

  // Next-state for multiplicand, product and iteration counter.
  always_comb begin
    mcand_d = mcand_q;
    prod_d  = prod_q;
    count_d = count_q;
    // Upper half plus (optionally) multiplicand; keep the carry as the new MSB.
    if (prod_q[0]) begin
      partial = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    end else begin
      partial = {1'b0, prod_q[2*WIDTH-1:WIDTH]};
    end
    step_prod = {partial, prod_q[WIDTH-1:1]};
    if (load) begin
      mcand_d = a_in;
      prod_d  = {{WIDTH{1'b0}}, b_in};
      count_d = CW'(WIDTH);
    end else if (step) begin
      prod_d  = step_prod;
      count_d = count_q - CW'(1);
    end else begin
      prod_d  = prod_q;
    end
  end

  // Multiplier state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mcand_q <= {WIDTH{1'b0}};
      prod_q  <= {(2*WIDTH){1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      count_q <= count_d;
    end
  end

  assign last    = (count_q == CW'(1));
  assign next_lo = step_prod[WIDTH-1:0];
  assign next_hi = step_prod[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execution stage behind the ALU control decoder.
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : alu_exec_unit_if slave -- start/operation/a/b in;
//               busy/done/result/hi/zero/overflow/illegal out (all registered)
// Single-cycle ops complete on the sampling edge; MUL runs WIDTH iterations
// in shift_add_multiplier while busy is high. Requests arriving while busy
// are dropped.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rstn,
  alu_exec_unit_if.slave  bus
);

  import alu_pkg::*;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             zero_q, zero_d;
  logic             overflow_q, overflow_d;
  logic             illegal_q, illegal_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] sum, diff, alu_res;
  logic             alu_ovf, alu_ill, slt_bit;
  logic             mul_load, mul_step, mul_last;
  logic [WIDTH-1:0] mul_lo, mul_hi;

  shift_add_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rstn    (rstn),
    .load    (mul_load),
    .step    (mul_step),
    .a_in    (bus.a),
    .b_in    (bus.b),
    .last    (mul_last),
    .next_lo (mul_lo),
    .next_hi (mul_hi)
  );

  // Single-cycle datapath; MUL and unknown codes fall to the illegal default
  // here, MUL being intercepted by the FSM before this result is used.
  always_comb begin
    sum     = bus.a + bus.b;
    diff    = bus.a - bus.b;
    // Signed less-than that survives subtraction overflow.
    slt_bit = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) ? bus.a[WIDTH-1] : diff[WIDTH-1];
    alu_res = {WIDTH{1'b0}};
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (bus.operation)
      OP_AND: alu_res = bus.a & bus.b;
      OP_OR:  alu_res = bus.a | bus.b;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
      OP_NOR: alu_res = ~(bus.a | bus.b);
      default: alu_ill = 1'b1;
    endcase
  end

  // Control FSM: next state, output-register next values, multiplier control.
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    hi_d       = hi_q;
    zero_d     = zero_q;
    overflow_d = overflow_q;
    illegal_d  = illegal_q;
    done_d     = 1'b0;
    busy_d     = busy_q;
    mul_load   = 1'b0;
    mul_step   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.operation == OP_MUL) begin
            mul_load = 1'b1;
            busy_d   = 1'b1;
            state_d  = ST_MUL;
          end else begin
            result_d   = alu_res;
            hi_d       = {WIDTH{1'b0}};
            zero_d     = (alu_res == {WIDTH{1'b0}});
            overflow_d = alu_ovf;
            illegal_d  = alu_ill;
            done_d     = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        mul_step = 1'b1;
        if (mul_last) begin
          result_d   = mul_lo;
          hi_d       = mul_hi;
          zero_d     = (mul_lo == {WIDTH{1'b0}});
          overflow_d = 1'b0;
          illegal_d  = 1'b0;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_MUL;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      result_q   <= {WIDTH{1'b0}};
      hi_q       <= {WIDTH{1'b0}};
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
      illegal_q  <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      hi_q       <= hi_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
      illegal_q  <= illegal_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.hi       = hi_q;
  assign bus.zero     = zero_q;
  assign bus.overflow = overflow_q;
  assign bus.illegal  = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed vectors with a scoreboard. Stimulus pushes the
// expected response (including the edge on which done must be registered);
// a negedge monitor pops and compares whenever done is seen.
module tb_alu_exec_unit;
  import alu_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  alu_exec_unit_if #(.WIDTH(W)) bus ();

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         z;
    logic         ov;
    logic         ill;
    int           edge_n;
    string        name;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected response.
  always @(negedge clk) begin
    exp_t e;
    if (rstn === 1'b1 && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk({e.name, ".result"},   bus.result,          e.res);
        chk({e.name, ".hi"},       bus.hi,              e.hi);
        chk({e.name, ".zero"},     32'(bus.zero),       32'(e.z));
        chk({e.name, ".overflow"}, 32'(bus.overflow),   32'(e.ov));
        chk({e.name, ".illegal"},  32'(bus.illegal),    32'(e.ill));
        chk({e.name, ".done_edge"}, 32'(cyc),           32'(e.edge_n));
      end
    end
  end

  // Drive one request at the current negedge; lat = edges from sample to done.
  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit push, input int lat,
                      input logic [W-1:0] eres, input logic [W-1:0] ehi,
                      input logic ez, input logic eov, input logic eill, input string name);
    exp_t e;
    bus.start     = 1'b1;
    bus.operation = op;
    bus.a         = a;
    bus.b         = b;
    if (push) begin
      e.res = eres; e.hi = ehi; e.z = ez; e.ov = eov; e.ill = eill;
      e.edge_n = cyc + 1 + lat;
      e.name = name;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Count negedges with busy high; optionally pulse an ADD request while busy.
  task automatic wait_mul(input int pulse_at, output int cnt);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.busy !== 1'b1) break;
      cnt++;
      if (i == pulse_at) begin
        bus.start = 1'b1; bus.operation = OP_ADD; bus.a = 32'd1; bus.b = 32'd1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (tests=%0d)", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int dones;
    rstn = 1'b0;
    bus.start = 1'b0; bus.operation = 4'b0000; bus.a = 32'd0; bus.b = 32'd0;
    #12;
    chk("reset.busy",     32'(bus.busy),     32'd0);
    chk("reset.done",     32'(bus.done),     32'd0);
    chk("reset.result",   bus.result,        32'd0);
    chk("reset.hi",       bus.hi,            32'd0);
    chk("reset.zero",     32'(bus.zero),     32'd0);
    chk("reset.overflow", 32'(bus.overflow), 32'd0);
    chk("reset.illegal",  32'(bus.illegal),  32'd0);
    @(negedge clk); rstn = 1'b1;
    @(negedge clk);

    // Single-cycle ops, back to back.
    send(OP_ADD, 32'd7, 32'd5, 1'b1, 0, 32'd12, 32'd0, 1'b0, 1'b0, 1'b0, "add_7_5");
    chk("add.busy_low", 32'(bus.busy), 32'd0);
    send(OP_ADD, 32'h7FFF_FFFF, 32'd1, 1'b1, 0, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 1'b0, "add_ovf");
    send(OP_SUB, 32'h1234, 32'h1234, 1'b1, 0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, "sub_eq");
    send(OP_SUB, 32'h8000_0000, 32'd1, 1'b1, 0, 32'h7FFF_FFFF, 32'd0, 1'b0, 1'b1, 1'b0, "sub_ovf");
    send(OP_SLT, 32'hFFFF_FFFF, 32'd1, 1'b1, 0, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, "slt_m1_1");
    send(OP_SLT, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 0, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, "slt_min_max");
    send(OP_SLT, 32'd1, 32'hFFFF_FFFF, 1'b1, 0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, "slt_1_m1");
    send(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 0, 32'hF000_F000, 32'd0, 1'b0, 1'b0, 1'b0, "and");
    send(OP_OR,  32'h0F0F_0000, 32'h0000_00F0, 1'b1, 0, 32'h0F0F_00F0, 32'd0, 1'b0, 1'b0, 1'b0, "or");
    send(OP_NOR, 32'd0, 32'd0, 1'b1, 0, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 1'b0, "nor_0_0");
    @(negedge clk);
    chk("hold.done",   32'(bus.done), 32'd0);
    chk("hold.result", bus.result,    32'hFFFF_FFFF);

    // Illegal codes, then a valid op clears illegal.
    send(OP_ILLEGAL_DEFAULT, 32'd5, 32'd6, 1'b1, 0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, "ill_1111");
    send(4'b0011, 32'd5, 32'd6, 1'b1, 0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, "ill_0011");
    send(OP_ADD, 32'd1, 32'd1, 1'b1, 0, 32'd2, 32'd0, 1'b0, 1'b0, 1'b0, "add_after_ill");

    // Multiply, then an ADD accepted in the done cycle.
    send(OP_MUL, 32'hFFFF_FFFF, 32'd2, 1'b1, 32, 32'hFFFF_FFFE, 32'd1, 1'b0, 1'b0, 1'b0, "mul_max_2");
    wait_mul(-1, cnt);
    chk("mul_max_2.busy_cycles", 32'(cnt), 32'd32);
    chk("mul_max_2.done_now", 32'(bus.done), 32'd1);
    send(OP_ADD, 32'd2, 32'd3, 1'b1, 0, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0, "add_in_done_cycle");

    send(OP_MUL, 32'd0, 32'd5, 1'b1, 32, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, "mul_0_5");
    wait_mul(-1, cnt);
    chk("mul_0_5.busy_cycles", 32'(cnt), 32'd32);
    send(OP_MUL, 32'h0001_0000, 32'h0001_0000, 1'b1, 32, 32'd0, 32'd1, 1'b1, 1'b0, 1'b0, "mul_2p32");
    wait_mul(-1, cnt);

    // Start pulsed while busy is ignored; exactly one done follows.
    send(OP_MUL, 32'd3, 32'd4, 1'b1, 32, 32'd12, 32'd0, 1'b0, 1'b0, 1'b0, "mul_ignore_start");
    wait_mul(5, cnt);
    chk("mul_ignore_start.busy_cycles", 32'(cnt), 32'd32);
    @(negedge clk);
    chk("mul_ignore_start.single_done", 32'(bus.done), 32'd0);

    // Asynchronous reset in the middle of a multiply.
    send(OP_ADD, 32'd7, 32'd5, 1'b1, 0, 32'd12, 32'd0, 1'b0, 1'b0, 1'b0, "add_pre_reset");
    send(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, "mul_abort");
    repeat (9) @(negedge clk);
    chk("abort.busy_before", 32'(bus.busy), 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("abort.busy",     32'(bus.busy),     32'd0);
    chk("abort.done",     32'(bus.done),     32'd0);
    chk("abort.result",   bus.result,        32'd0);
    chk("abort.hi",       bus.hi,            32'd0);
    chk("abort.zero",     32'(bus.zero),     32'd0);
    chk("abort.overflow", 32'(bus.overflow), 32'd0);
    chk("abort.illegal",  32'(bus.illegal),  32'd0);
    @(negedge clk); rstn = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    chk("abort.no_done", 32'(dones), 32'd0);
    send(OP_ADD, 32'd20, 32'd22, 1'b1, 0, 32'd42, 32'd0, 1'b0, 1'b0, 1'b0, "add_post_reset");
    @(negedge clk);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
